// File: rtl/wb_regfile_if.sv
// MEM/WB-to-regfile bundle: write-back inputs, ID read ports,
// forwarding value, commit strobe and retire counter.
interface wb_regfile_if #(
  parameter int DATA_W = 32,
  parameter int ADDR_W = 5,
  parameter int CNT_W  = 32
);
  logic [DATA_W-1:0] memData;
  logic [DATA_W-1:0] aluResult;
  logic [ADDR_W-1:0] writeReg;
  logic [1:0]        WB;
  logic [ADDR_W-1:0] readReg1;
  logic [ADDR_W-1:0] readReg2;
  logic [DATA_W-1:0] readData1;
  logic [DATA_W-1:0] readData2;
  logic [DATA_W-1:0] wbData;
  logic              wbValid;
  logic [CNT_W-1:0]  retireCount;

  modport master (
    output memData, aluResult, writeReg, WB,
    output readReg1, readReg2,
    input  readData1, readData2,
    input  wbData, wbValid, retireCount
  );

  modport slave (
    input  memData, aluResult, writeReg, WB,
    input  readReg1, readReg2,
    output readData1, readData2,
    output wbData, wbValid, retireCount
  );
endinterface

// File: rtl/wb_regfile.sv
// Write-back stage + 32x32 register file with retire counter.
// Ports: clock, reset_n (async low), bus (wb_regfile_if.slave).
// Option: WB_BYPASS_EN forwards the committing value to reads.
module wb_regfile #(
  parameter int DATA_W = 32,
  parameter int ADDR_W = 5,
  parameter int CNT_W  = 32
) (
  input  logic           clock,
  input  logic           reset_n,
  wb_regfile_if.slave    bus
);
  localparam int NREG = 1 << ADDR_W;

  logic [DATA_W-1:0] regs_q [1:NREG-1];
  logic [CNT_W-1:0]  retire_q;
  logic [CNT_W-1:0]  retire_d;
  logic [DATA_W-1:0] wb_data;
  logic              wb_valid;
  logic [DATA_W-1:0] rd1;
  logic [DATA_W-1:0] rd2;

  assign wb_data  = bus.WB[0] ? bus.memData
                              : bus.aluResult;
  assign wb_valid = bus.WB[1] &&
                    (bus.writeReg != '0);

  assign retire_d = wb_valid
                  ? retire_q + CNT_W'(1)
                  : retire_q;

  always_ff @(posedge clock or negedge reset_n) begin
    if (!reset_n) begin
      for (int i = 1; i < NREG; i++)
        regs_q[i] <= '0;
      retire_q <= '0;
    end else begin
      if (wb_valid)
        regs_q[bus.writeReg] <= wb_data;
      retire_q <= retire_d;
    end
  end

  always_comb begin
    rd1 = '0;
    if (bus.readReg1 != '0)
      rd1 = regs_q[bus.readReg1];
`ifdef WB_BYPASS_EN
    if (wb_valid &&
        bus.readReg1 == bus.writeReg)
      rd1 = wb_data;
`endif
  end

  always_comb begin
    rd2 = '0;
    if (bus.readReg2 != '0)
      rd2 = regs_q[bus.readReg2];
`ifdef WB_BYPASS_EN
    if (wb_valid &&
        bus.readReg2 == bus.writeReg)
      rd2 = wb_data;
`endif
  end

  assign bus.readData1   = rd1;
  assign bus.readData2   = rd2;
  assign bus.wbData      = wb_data;
  assign bus.wbValid     = wb_valid;
  assign bus.retireCount = retire_q;
endmodule
